// File: rtl/key_pkg.sv
// Shared types, widths and helpers for the push-button front end.
package key_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned DCNT_W   = 8;
  localparam int unsigned RCNT_W   = 16;
  localparam int unsigned MS_PER_S = 1000;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    DEB_P = 3'd1,
    WAIT  = 3'd2,
    RPT   = 3'd3,
    DEB_R = 3'd4
  } key_state_e;

  // Saturating increments: counters stop at their compare value.
  function automatic logic [DCNT_W-1:0] dcnt_step(input logic [DCNT_W-1:0] cnt,
                                                  input logic [DCNT_W-1:0] lim);
    return (cnt >= lim) ? cnt : cnt + DCNT_W'(1);
  endfunction

  function automatic logic [RCNT_W-1:0] rcnt_step(input logic [RCNT_W-1:0] cnt,
                                                  input logic [RCNT_W-1:0] lim);
    return (cnt >= lim) ? cnt : cnt + RCNT_W'(1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One button: two-flop synchroniser, debounce/auto-repeat FSM and its counters.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  input  logic tick,
  output logic press,
  output logic rel,
  output logic held
);

  localparam logic [DCNT_W-1:0] DEB_LIM  = DCNT_W'(DEBOUNCE_MS);
  localparam logic [RCNT_W-1:0] DLY_LIM  = RCNT_W'(REPEAT_DELAY_MS);
  localparam logic [RCNT_W-1:0] RATE_LIM = RCNT_W'(REPEAT_RATE_MS);
  localparam bit                RPT_EN   = (REPEAT_RATE_MS != 0);

  logic              sync1;
  logic              sync2;
  logic              ks;
  key_state_e        state;
  key_state_e        ret_state;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dcnt_inc;
  logic [RCNT_W-1:0] rcnt;
  logic [RCNT_W-1:0] rcnt_inc;
  logic [RCNT_W-1:0] rcnt_lim;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign ks       = ~sync2;
  assign rcnt_lim = (state == RPT) ? RATE_LIM : DLY_LIM;
  assign dcnt_inc = dcnt_step(dcnt, DEB_LIM);
  assign rcnt_inc = rcnt_step(rcnt, rcnt_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_state <= WAIT;
      dcnt      <= '0;
      rcnt      <= '0;
      press     <= 1'b0;
      rel       <= 1'b0;
      held      <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE: begin
          if (ks) begin
            dcnt  <= '0;
            state <= DEB_P;
          end
        end
        DEB_P: begin
          if (!ks) begin
            state <= IDLE;
          end else if (tick) begin
            dcnt <= dcnt_inc;
            if (dcnt_inc == DEB_LIM) begin
              press <= 1'b1;
              held  <= 1'b1;
              rcnt  <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT, RPT: begin
          // Release debounce remembers where to resume so repeat timing freezes.
          if (!ks) begin
            dcnt      <= '0;
            ret_state <= state;
            state     <= DEB_R;
          end else if (tick) begin
            if (state == WAIT && RPT_EN && rcnt_inc == DLY_LIM) begin
              press <= 1'b1;
              rcnt  <= '0;
              state <= RPT;
            end else if (state == RPT && rcnt_inc == RATE_LIM) begin
              press <= 1'b1;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt_inc;
            end
          end
        end
        DEB_R: begin
          if (ks) begin
            state <= ret_state;
          end else if (tick) begin
            dcnt <= dcnt_inc;
            if (dcnt_inc == DEB_LIM) begin
              rel   <= 1'b1;
              held  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Push-button front end: shared 1 ms prescaler feeding one debounce channel per key.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] RELEASE,
  output logic [N_KEYS-1:0] HELD
);

  localparam int unsigned   TICK_DIV = CLK_HZ / MS_PER_S;
  localparam int unsigned   PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_MAX);

  // Free-running millisecond prescaler shared by all keys.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) u_channel (
      .clk  (CLOCK_50),
      .rst_n(RESET_N),
      .key  (KEY[i]),
      .tick (tick),
      .press(PRESS[i]),
      .rel  (RELEASE[i]),
      .held (HELD[i])
    );
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed lab scenarios plus random key activity against a run-length model.
module tb_key_pulse_gen;

  localparam int unsigned NK     = 2;
  localparam int unsigned CLK_HZ = 10000;
  localparam int unsigned P      = CLK_HZ / 1000;
  localparam int unsigned DEB    = 2;
  localparam int unsigned DLY    = 5;
  localparam int unsigned RATE   = 2;

  typedef struct packed {
    logic [15:0] run;
    logic [15:0] hold;
    logic        started;
    logic        held;
    logic        press;
    logic        rel;
  } mst_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key   = '1;
  logic [NK-1:0] press_a, rel_a, held_a;
  logic [NK-1:0] press_b, rel_b, held_b;

  int checks   = 0;
  int failures = 0;

  key_pulse_gen #(
    .N_KEYS(NK), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB),
    .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(RATE)
  ) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key),
    .PRESS(press_a), .RELEASE(rel_a), .HELD(held_a)
  );

  key_pulse_gen #(
    .N_KEYS(NK), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB),
    .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(0)
  ) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key),
    .PRESS(press_b), .RELEASE(rel_b), .HELD(held_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a change in the synchronised level restarts its run; a run that differs
  // from the debounced level flips it after DEB ticks; while held, steady-pressed ticks drive repeats.
  function automatic mst_t mstep(input mst_t s, input logic ks, input logic ksp,
                                 input logic tk, input int unsigned rate);
    mst_t n;
    n       = s;
    n.press = 1'b0;
    n.rel   = 1'b0;
    if (ks != ksp) begin
      n.run = '0;
    end else if (ks != s.held) begin
      if (tk) begin
        n.run = s.run + 16'd1;
        if (n.run == 16'(DEB)) begin
          n.run  = '0;
          n.held = ks;
          if (ks) begin
            n.press   = 1'b1;
            n.hold    = '0;
            n.started = 1'b0;
          end else begin
            n.rel = 1'b1;
          end
        end
      end
    end else if (ks && tk && rate != 0) begin
      n.hold = s.hold + 16'd1;
      if (n.hold == (s.started ? 16'(rate) : 16'(DLY))) begin
        n.press   = 1'b1;
        n.hold    = '0;
        n.started = 1'b1;
      end
    end
    return n;
  endfunction

  mst_t          ms [2][NK];
  int unsigned   ecnt;
  logic [NK-1:0] d1, d2, ks_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt    <= 0;
      d1      <= '0;
      d2      <= '0;
      ks_prev <= '0;
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < NK; k++) ms[c][k] <= '0;
    end else begin
      ecnt    <= ecnt + 1;
      d1      <= ~key;
      d2      <= d1;
      ks_prev <= d2;
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < NK; k++)
          ms[c][k] <= mstep(ms[c][k], d2[k], ks_prev[k], (ecnt % P) == P - 1,
                            (c == 0) ? RATE : 0);
    end
  end

  function automatic logic [3*NK-1:0] model_vec(input int c);
    logic [NK-1:0] p, r, h;
    for (int k = 0; k < NK; k++) begin
      p[k] = ms[c][k].press;
      r[k] = ms[c][k].rel;
      h[k] = ms[c][k].held;
    end
    return {p, r, h};
  endfunction

  task automatic step();
    @(negedge clk);
    check("cycle_a", {press_a, rel_a, held_a}, model_vec(0));
    check("cycle_b", {press_b, rel_b, held_b}, model_vec(1));
  endtask

  int   w_np_a[NK], w_nr_a[NK], w_np_b[NK], w_fp_a[NK], w_fr_a[NK];
  int   w_both;
  logic w_held_fp, w_held_fr;
  int   w_pt[$];

  task automatic watch(input int n);
    for (int k = 0; k < NK; k++) begin
      w_np_a[k] = 0; w_nr_a[k] = 0; w_np_b[k] = 0; w_fp_a[k] = -1; w_fr_a[k] = -1;
    end
    w_pt.delete();
    w_both    = 0;
    w_held_fp = 1'bx;
    w_held_fr = 1'bx;
    for (int c = 1; c <= n; c++) begin
      step();
      if (press_a == '1) w_both++;
      for (int k = 0; k < NK; k++) begin
        if (press_a[k]) begin
          w_np_a[k]++;
          if (w_fp_a[k] < 0) begin
            w_fp_a[k] = c;
            if (k == 0) w_held_fp = held_a[0];
          end
          if (k == 0) w_pt.push_back(c);
        end
        if (rel_a[k]) begin
          w_nr_a[k]++;
          if (w_fr_a[k] < 0) begin
            w_fr_a[k] = c;
            if (k == 0) w_held_fr = held_a[0];
          end
        end
        if (press_b[k]) w_np_b[k]++;
      end
    end
  endtask

  // Return on the falling edge just after a prescaler tick, so latencies are deterministic.
  task automatic align();
    for (int g = 0; g < 2 * P; g++) begin
      step();
      if ((ecnt % P) == 0) break;
    end
  endtask

  initial begin
    int len;
    int g1, g2, p_before;

    rst_n = 1'b0;
    key   = '1;
    repeat (3) step();
    check("rst_a", {press_a, rel_a, held_a}, 0);
    check("rst_b", {press_b, rel_b, held_b}, 0);
    rst_n = 1'b1;
    watch(200);
    check("idle_press", w_np_a[0] + w_np_a[1] + w_np_b[0] + w_np_b[1], 0);
    check("idle_rel", w_nr_a[0] + w_nr_a[1], 0);

    // Held press with auto-repeat.
    align();
    key[0] = 1'b0;
    watch(100);
    g1 = (w_pt.size() >= 2) ? w_pt[1] - w_pt[0] : -1;
    g2 = (w_pt.size() >= 3) ? w_pt[2] - w_pt[1] : -1;
    check("press0_latency", w_fp_a[0], 20);
    check("press0_held_same_cycle", w_held_fp, 1);
    check("press0_pulses_100", w_pt.size(), 3);
    check("repeat_delay_gap", g1, 50);
    check("repeat_rate_gap", g2, 20);
    check("press1_quiet", w_np_a[1], 0);

    // Release after hold.
    align();
    key[0] = 1'b1;
    watch(60);
    check("rel0_latency", w_fr_a[0], 20);
    check("rel0_count", w_nr_a[0], 1);
    check("rel0_held_same_cycle", w_held_fr, 0);
    check("rel0_no_press", w_np_a[0], 0);

    // Bounce restarts debounce.
    align();
    key[0] = 1'b0;
    watch(12);
    p_before = w_np_a[0];
    key[0] = 1'b1;
    watch(3);
    p_before += w_np_a[0];
    key[0] = 1'b0;
    watch(40);
    check("bounce_no_early_press", p_before, 0);
    check("bounce_press_latency", w_fp_a[0], 15);
    key[0] = 1'b1;
    watch(60);
    check("bounce_release", w_nr_a[0], 1);

    // Simultaneous presses.
    align();
    key = '0;
    watch(30);
    check("both_single_cycle", w_both, 1);
    check("both_key1_latency", w_fp_a[1], 20);

    // Asynchronous reset while held, key still down afterwards.
    watch(5);
    check("held_before_rst", held_a, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_a", {press_a, rel_a, held_a}, 0);
    check("rst_async_b", {press_b, rel_b, held_b}, 0);
    step();
    step();
    rst_n = 1'b1;
    watch(30);
    check("rst_repress_latency", w_fp_a[0], 20);
    check("rst_repress_b", w_np_b[1], 1);
    key = '1;
    watch(60);

    // Repeat disabled on dut_b versus enabled on dut_a.
    align();
    key[0] = 1'b0;
    watch(200);
    check("norepeat_single_press", w_np_b[0], 1);
    check("repeat_press_count", w_np_a[0], 8);
    key[0] = 1'b1;
    watch(60);

    // Random key activity, bounces and long holds mixed, one mid-run reset.
    for (int seg = 0; seg < 120; seg++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 2) == 0) key[k] = ~key[k];
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 300))
                                        : int'($urandom_range(1, 25));
      repeat (len) step();
      if (seg == 60) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    key = '1;
    repeat (60) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Push-button front end for the board's counter labs. It synchronises and debounces the active-low `KEY` buttons and turns each press into clean single-cycle `PRESS` and `RELEASE` pulses, with typematic auto-repeat while a key is held. It sits between the raw `KEY` pins and any counter or register that needs one step per press. Those consumers clock on `CLOCK_50` and use `PRESS` as an enable; they never use a button as a clock.

## Interface
Parameters:
- `N_KEYS`, 2: number of buttons handled.
- `CLK_HZ`, 50000000: `CLOCK_50` frequency. Must be a multiple of 1000.
- `DEBOUNCE_MS`, 10: consecutive stable ms ticks required to accept a level change. Range 1..255.
- `REPEAT_DELAY_MS`, 500: hold time before the first repeat pulse. Range 1..65535.
- `REPEAT_RATE_MS`, 100: period of repeat pulses after that. 0 disables repeat. Range 0..65535.

Ports (one clock; reset is asynchronous and active-low):
- `CLOCK_50`, in, 1: sole clock, rising edge.
- `RESET_N`, in, 1: asynchronous active-low reset.
- `KEY`, in, `N_KEYS`: raw buttons, asynchronous, 0 = pressed.
- `PRESS`, out, `N_KEYS`: one-cycle pulse on an accepted press and on each auto-repeat.
- `RELEASE`, out, `N_KEYS`: one-cycle pulse on an accepted release.
- `HELD`, out, `N_KEYS`: debounced level, 1 = pressed.

## Operation
- Reset: `PRESS`=0, `RELEASE`=0, `HELD`=0, all FSMs in `IDLE`, all counters 0. Synchroniser flops reset to 1 (released).
- Synchroniser: 2 flops per key; `ks[i]` is the inverted output (1 = pressed).
- Prescaler: one shared counter 0..CLK_HZ/1000-1. `tick` is high for one cycle when the count equals the maximum; the counter then wraps to 0.
- Per-key FSM (encoding in package):
  - `IDLE`: `HELD`=0. On `ks`=1, clear `dcnt` and go to `DEB_P`.
  - `DEB_P`: if `ks`=0, go to `IDLE` (bounce, no output). Otherwise `dcnt` increments on each tick. When `dcnt` reaches `DEBOUNCE_MS`, pulse `PRESS`, set `HELD`=1, clear `rcnt`, go to `WAIT`.
  - `WAIT`: if `ks`=0, clear `dcnt` and go to `DEB_R`. Otherwise `rcnt` increments on each tick. When `rcnt` reaches `REPEAT_DELAY_MS` and `REPEAT_RATE_MS`≠0, pulse `PRESS`, clear `rcnt`, go to `RPT`.
  - `RPT`: same release check as `WAIT`. When `rcnt` reaches `REPEAT_RATE_MS`, pulse `PRESS` and clear `rcnt`.
  - `DEB_R`: if `ks`=1, return to the state that entered `DEB_R` with `rcnt` preserved. Repeat timing is frozen during release debounce. Otherwise `dcnt` increments on each tick. When it reaches `DEBOUNCE_MS`, pulse `RELEASE`, set `HELD`=0, go to `IDLE`.
- Counters saturate at their compare value and never wrap: `dcnt` is 8 bits, `rcnt` is 16 bits.
- Keys are fully independent. Simultaneous presses produce simultaneous pulses.
- `PRESS` and `RELEASE` are never high together on the same key.

## Timing
- All outputs are registered. A pulse is high in the cycle after the edge on which the FSM transition occurs.
- Press latency from a clean `KEY` fall: 2 cycles (synchroniser), plus `DEBOUNCE_MS`-1 to `DEBOUNCE_MS` ms (tick phase), plus 1 cycle.
- First repeat comes `REPEAT_DELAY_MS` ticks after the first `PRESS`. Later repeats come every `REPEAT_RATE_MS` ticks, exact in cycles (CLK_HZ/1000 × rate).
- `RESET_N` asserted mid-press: outputs clear immediately and asynchronously. On deassertion a still-held key must debounce again before `PRESS`.
- `RESET_N` deassertion is synchronised externally; this block does not resynchronise it.

## Structure
- Package `key_pkg` holds the FSM state localparams (`IDLE`, `DEB_P`, `WAIT`, `RPT`, `DEB_R`, 3-bit) and the counter widths (8, 16).
- Sub-module `key_channel` holds one key: synchroniser, FSM, `dcnt`, `rcnt`. It is instantiated `N_KEYS` times by generate.
- Top level holds the shared prescaler and fans `tick` out to every channel.

## Test plan
All scenarios use `CLK_HZ`=10000 (tick every 10 cycles), `DEBOUNCE_MS`=2, `REPEAT_DELAY_MS`=5, `REPEAT_RATE_MS`=2.
- Reset with `KEY`=2'b11 -> `PRESS`=`RELEASE`=`HELD`=0. No pulses over 200 cycles.
- `KEY[0]` held low 100 cycles -> exactly one `PRESS[0]` within 20..23 cycles of the fall. `HELD[0]`=1 from that pulse on. Repeats at +50 cycles, then every 20 cycles.
- `KEY[0]` low for 12 cycles, high for 3, then low -> debounce restarts. No `PRESS` before 2 full stable ticks after the last fall.
- Release after a held press -> one `RELEASE[0]` 20..23 cycles after the rise. `HELD[0]`=0 in the same cycle. No `PRESS` after it.
- Both keys pressed on the same cycle -> `PRESS`=2'b11 in a single cycle.
- `RESET_N` pulsed low while `HELD`=1 -> outputs 0 at once. With the key still held, `PRESS` is re-issued 20..23 cycles after reset release.
- Rerun with `REPEAT_RATE_MS`=0 and hold for 200 cycles -> exactly one `PRESS`.
